// File: rtl/rom_port_arbiter_pkg.sv
// rtl/rom_port_arbiter_pkg.sv - shared constants and types for the instruction ROM port arbiter
package rom_port_arbiter_pkg;

    localparam int PORT_FETCH = 0;
    localparam int PORT_DBG   = 1;

    localparam int DEF_PC_W      = 30;
    localparam int DEF_ROM_DEPTH = 7;
    localparam int DEF_IDX_W     = 4;

    localparam logic ERR_NONE     = 1'b0;
    localparam logic ERR_BAD_ADDR = 1'b1;

    typedef logic [15:0] rom_word_t;

    // Word index as seen by the ROM itself: byte address halved, truncated to DEF_IDX_W.
    function automatic logic [DEF_IDX_W-1:0] rom_word_idx(input logic [DEF_PC_W-1:0] pc);
        return pc[DEF_IDX_W:1];
    endfunction

endpackage

// File: rtl/rom_port_arbiter_if.sv
// rtl/rom_port_arbiter_if.sv - two-port request/response bundle between requesters and the ROM arbiter
interface rom_port_arbiter_if
    import rom_port_arbiter_pkg::*;
#(
    parameter int PC_W = DEF_PC_W
) ();

    logic [1:0]      req_valid;
    logic [PC_W-1:0] req_addr0;
    logic [PC_W-1:0] req_addr1;
    logic [1:0]      req_ready;
    logic [1:0]      rsp_valid;
    rom_word_t       rsp_data0;
    rom_word_t       rsp_data1;
    logic [1:0]      rsp_err;
    logic [1:0]      rsp_ready;

    modport master (
        output req_valid, req_addr0, req_addr1, rsp_ready,
        input  req_ready, rsp_valid, rsp_data0, rsp_data1, rsp_err
    );

    modport slave (
        input  req_valid, req_addr0, req_addr1, rsp_ready,
        output req_ready, rsp_valid, rsp_data0, rsp_data1, rsp_err
    );

endinterface

// File: rtl/rom_port_arbiter_rr_arb2.sv
// rtl/rom_port_arbiter_rr_arb2.sv - two-way round-robin arbiter, one-hot grant, pointer flop inside
module rom_rr_arb2 (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [1:0] elig,
    output logic [1:0] grant
);

    logic rr_ptr;

    always_comb begin
        grant = 2'b00;
        unique case (elig)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = rr_ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // The loser of this cycle gets priority on the next contended cycle.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rr_ptr <= 1'b0;
        end else if (grant[0]) begin
            rr_ptr <= 1'b1;
        end else if (grant[1]) begin
            rr_ptr <= 1'b0;
        end
    end

endmodule

// File: rtl/rom_port_arbiter.sv
// rtl/rom_port_arbiter.sv - shares one combinational instruction ROM between fetch and debug ports
module rom_port_arbiter
    import rom_port_arbiter_pkg::*;
#(
    parameter int PC_W      = DEF_PC_W,
    parameter int ROM_DEPTH = DEF_ROM_DEPTH
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    rom_port_arbiter_if.slave bus,
    output logic [PC_W-1:0] rom_pc,
    input  rom_word_t       rom_data
);

    localparam logic [PC_W-2:0] DEPTH_IDX = (PC_W-1)'(ROM_DEPTH);

    logic [1:0] elig;
    logic [1:0] grant;
    logic       addr_err;
    rom_word_t  rsp_word;
    logic [1:0] rsp_valid_q;
    logic [1:0] rsp_err_q;
    rom_word_t  rsp_data0_q;
    rom_word_t  rsp_data1_q;

    // A port holding an unconsumed response cannot be granted again.
    always_comb begin
        elig = 2'b00;
        if (sys_rst_n) begin
            elig = bus.req_valid & (~rsp_valid_q | bus.rsp_ready);
        end
    end

    rom_rr_arb2 u_arb (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .elig      (elig),
        .grant     (grant)
    );

    assign bus.req_ready = grant;

    always_comb begin
        rom_pc = '0;
        if (grant[PORT_FETCH]) begin
            rom_pc = bus.req_addr0;
        end else if (grant[PORT_DBG]) begin
            rom_pc = bus.req_addr1;
        end
    end

    // Range check uses the full word index, not the truncated ROM index.
    always_comb begin
        addr_err = ERR_NONE;
        if (rom_pc[0] || (rom_pc[PC_W-1:1] >= DEPTH_IDX)) begin
            addr_err = ERR_BAD_ADDR;
        end
        rsp_word = (addr_err == ERR_BAD_ADDR) ? 16'h0000 : rom_data;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rsp_valid_q <= 2'b00;
            rsp_err_q   <= 2'b00;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (grant[k]) begin
                    rsp_valid_q[k] <= 1'b1;
                    rsp_err_q[k]   <= addr_err;
                end else if (rsp_valid_q[k] && bus.rsp_ready[k]) begin
                    rsp_valid_q[k] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rsp_data0_q <= '0;
            rsp_data1_q <= '0;
        end else begin
            if (grant[PORT_FETCH]) begin
                rsp_data0_q <= rsp_word;
            end
            if (grant[PORT_DBG]) begin
                rsp_data1_q <= rsp_word;
            end
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_data0 = rsp_data0_q;
    assign bus.rsp_data1 = rsp_data1_q;

endmodule
